// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe move controller and its checker.
// Cell codes match the win checker's encoding: 00 empty, 01 player A, 10 player B.
package tictactoe_pkg;

    typedef logic [1:0] cell_t;

    localparam cell_t CELL_EMPTY = 2'b00;
    localparam cell_t CELL_A     = 2'b01;
    localparam cell_t CELL_B     = 2'b10;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        CHECK = 2'b01,
        OVER  = 2'b10
    } ctrl_state_t;

    localparam int         NUM_CELLS = 9;
    localparam logic [3:0] MAX_POS   = 4'd8;
    localparam logic [3:0] MAX_MOVES = 4'd9;

    function automatic cell_t player_code(input logic player);
        if (player) begin
            return CELL_B;
        end else begin
            return CELL_A;
        end
    endfunction

endpackage

// File: rtl/tictactoe_move_ctrl_chk.sv
// Invariant checker for tictactoe_move_ctrl, observing only its ports.
// CHECK is the only state where both move_ready and game_over are low.
module tictactoe_move_ctrl_chk (
    input logic       clk,
    input logic       rst,
    input logic       move_ready,
    input logic       game_over,
    input logic       wina,
    input logic       winb,
    input logic [3:0] move_count
);

    logic in_check_s;

    // Decode the CHECK cycle from the controller's visible outputs.
    always_comb begin
        in_check_s = !move_ready && !game_over;
    end

    a_single_winner: assert property (@(posedge clk) disable iff (rst)
        in_check_s |-> !(wina && winb));

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        move_count <= 4'd9);

endmodule

// File: rtl/tictactoe_move_ctrl.sv
// Game controller upstream of the combinational win checker: validates moves,
// owns the registered board, alternates turns and ends the game on win or draw.
import tictactoe_pkg::*;

module tictactoe_move_ctrl #(
    parameter bit FIRST_PLAYER = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    input  logic       wina,
    input  logic       winb,
    output logic [0:1] s1,
    output logic [0:1] s2,
    output logic [0:1] s3,
    output logic [0:1] s4,
    output logic [0:1] s5,
    output logic [0:1] s6,
    output logic [0:1] s7,
    output logic [0:1] s8,
    output logic [0:1] s9,
    output logic       move_ready,
    output logic       move_err,
    output logic       turn,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw,
    output logic [3:0] move_count
);

    ctrl_state_t state_r;
    ctrl_state_t state_next_s;
    cell_t       board_r [NUM_CELLS];
    logic        pos_ok_s;
    logic        cell_free_s;
    logic        accept_s;
    logic        reject_s;

    assign s1 = board_r[0];
    assign s2 = board_r[1];
    assign s3 = board_r[2];
    assign s4 = board_r[3];
    assign s5 = board_r[4];
    assign s6 = board_r[5];
    assign s7 = board_r[6];
    assign s8 = board_r[7];
    assign s9 = board_r[8];

    // Move validation: only PLAY accepts; OVER rejects everything; CHECK ignores input.
    always_comb begin
        pos_ok_s    = (move_pos <= MAX_POS);
        cell_free_s = 1'b0;
        accept_s    = 1'b0;
        reject_s    = 1'b0;
        if (pos_ok_s) begin
            cell_free_s = (board_r[move_pos] == CELL_EMPTY);
        end else begin
            cell_free_s = 1'b0;
        end
        case (state_r)
            PLAY: begin
                accept_s = move_valid && cell_free_s;
                reject_s = move_valid && !cell_free_s;
            end
            OVER: begin
                reject_s = move_valid;
            end
            default: begin
                accept_s = 1'b0;
                reject_s = 1'b0;
            end
        endcase
    end

    // State register; rst and new_game both return to PLAY.
    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            state_r <= PLAY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; CHECK always resolves in a single cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            PLAY: begin
                if (accept_s) begin
                    state_next_s = CHECK;
                end else begin
                    state_next_s = PLAY;
                end
            end
            CHECK: begin
                if (wina || winb || (move_count == MAX_MOVES)) begin
                    state_next_s = OVER;
                end else begin
                    state_next_s = PLAY;
                end
            end
            OVER: begin
                state_next_s = OVER;
            end
            default: begin
                state_next_s = PLAY;
            end
        endcase
    end

    // Handshake decode: the source may present a move only in PLAY.
    always_comb begin
        move_ready = 1'b0;
        if (state_r == PLAY) begin
            move_ready = 1'b1;
        end else begin
            move_ready = 1'b0;
        end
    end

    // Board, turn and result registers; a move coinciding with new_game is dropped.
    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                board_r[i] <= CELL_EMPTY;
            end
            turn       <= FIRST_PLAYER;
            move_count <= 4'd0;
            winner     <= CELL_EMPTY;
            draw       <= 1'b0;
            move_err   <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            move_err  <= reject_s;
            game_over <= (state_next_s == OVER);
            if (accept_s) begin
                board_r[move_pos] <= player_code(turn);
                if (move_count != MAX_MOVES) begin
                    move_count <= move_count + 4'd1;
                end
            end
            // A wins by priority if both lines are reported.
            if (state_r == CHECK) begin
                if (wina) begin
                    winner <= CELL_A;
                end else if (winb) begin
                    winner <= CELL_B;
                end else if (move_count == MAX_MOVES) begin
                    winner <= CELL_EMPTY;
                    draw   <= 1'b1;
                end else begin
                    turn <= ~turn;
                end
            end
        end
    end

endmodule
